// File: rtl/ws2812_layer_sched.sv
// Round-robin scheduler sharing one WS2812 serializer among N_LAYERS frame requesters.
// Grant/start one cycle after a request is seen in IDLE; forced-low latch gap after every transfer.
module ws2812_layer_sched #(
  parameter int N_LAYERS   = 8,
  parameter int GAP_CYCLES = 4000,
  parameter int TIMEOUT    = 65535,
  localparam int SW        = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                enable_in,
  input  logic [N_LAYERS-1:0] layer_req_in,
  input  logic                ser_done_in,
  output logic                ser_start_out,
  output logic [SW-1:0]       ser_sel_out,
  output logic [N_LAYERS-1:0] layer_grant_out,
  output logic [N_LAYERS-1:0] layer_ack_out,
  output logic                abort_out,
  output logic                busy_out,
  output logic [7:0]          frame_cnt_out
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0]       GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [15:0]         WD_LAST  = 16'(TIMEOUT - 1);
  localparam logic [N_LAYERS-1:0] ONE      = N_LAYERS'(1);

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         rr_q, rr_d, sel_q, sel_d;
  logic [N_LAYERS-1:0]   grant_q, grant_d, ack_q, ack_d;
  logic                  abort_q, abort_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [15:0]           wdog_q, wdog_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  pick_vld;
  logic [SW-1:0]         pick_idx;

  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_LAYERS) s = s - N_LAYERS;
    return SW'(s);
  endfunction

  // Scan downward so the lowest offset from rr_q wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (layer_req_in[wrap_add(rr_q, i)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_add(rr_q, i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    ack_d   = '0;
    abort_d = 1'b0;
    cnt_d   = cnt_q;
    wdog_d  = wdog_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (enable_in && pick_vld) begin
          state_d = START;
          sel_d   = pick_idx;
          grant_d = ONE << pick_idx;
        end
      end
      START: begin
        state_d = BUSY;
        wdog_d  = '0;
      end
      BUSY: begin
        wdog_d = wdog_q + 16'd1;
        if (ser_done_in) begin
          ack_d   = grant_q;
          cnt_d   = cnt_q + 8'd1;
          rr_d    = wrap_add(sel_q, 1);
          gap_d   = GAP_LOAD;
          grant_d = '0;
          state_d = GAP;
        end else if (wdog_q == WD_LAST) begin
          abort_d = 1'b1;
          rr_d    = wrap_add(sel_q, 1);
          gap_d   = GAP_LOAD;
          grant_d = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
      wdog_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      gap_q   <= gap_d;
    end
  end

  assign ser_start_out   = (state_q == START);
  assign busy_out        = (state_q != IDLE);
  assign ser_sel_out     = sel_q;
  assign layer_grant_out = grant_q;
  assign layer_ack_out   = ack_q;
  assign abort_out       = abort_q;
  assign frame_cnt_out   = cnt_q;

endmodule

// File: doc/ws2812_layer_sched.md
Name: ws2812_layer_sched

Overview:
- Round-robin scheduler that shares one WS2812 bit serializer and frame-RAM read port among 8 layer requesters.
- Each layer raises a request when its frame buffer is complete. The scheduler grants one layer at a time, pulses start to the serializer, and waits for done.
- After each transfer it enforces a latch (reset) gap with the line held low, then re-arbitrates.
- Includes a watchdog on stuck transfers and a completed-frame counter for the FPS logic.

Parameters:
- N_LAYERS, 8, number of requesters/output lines (sel width = clog2(N_LAYERS)).
- GAP_CYCLES, 4000, sys_clk cycles of forced-low latch gap after every transfer (>=50 us at sys_clk).
- TIMEOUT, 65535, max sys_clk cycles in BUSY before abort; counter width 16.

Ports:
- clk_in  in  1  system clock (sys_clk domain).
- rst_in  in  1  reset.
- enable_in  in  1  high = new grants allowed; low = finish current transfer, then hold in IDLE.
- layer_req_in  in  N_LAYERS  level request per layer, frame ready.
- ser_done_in  in  1  one-cycle pulse from serializer, frame fully shifted out.
- ser_start_out  out  1  one-cycle start pulse to serializer.
- ser_sel_out  out  3  index of granted layer (RAM bank / output mux select).
- layer_grant_out  out  N_LAYERS  one-hot grant; all zero when no line is driven (mux forces line low).
- layer_ack_out  out  N_LAYERS  one-cycle pulse to a layer on successful completion.
- abort_out  out  1  one-cycle pulse on watchdog abort.
- busy_out  out  1  high in START, BUSY, GAP.
- frame_cnt_out  out  8  successful transfers, wraps 255->0.

Interface decision:
- One clock; reset is synchronous and active-high.
- Ports are named clk_in and rst_in.

Behaviour:
- Reset (rst_in sampled high at a clk_in edge):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: grant, ack, start, abort, busy, sel, frame_cnt.
  - Gap and watchdog counters 0.
  - Reset mid-transfer drops the grant immediately. The serializer is reset by the same signal.
- States: IDLE, START, BUSY, GAP.
- IDLE:
  - If enable_in=1 and any layer_req_in bit is set, pick the first requesting index scanning rr_ptr, rr_ptr+1, ... mod N_LAYERS.
  - Register sel and one-hot grant, then go to START.
  - Otherwise stay in IDLE.
- START:
  - Lasts exactly 1 cycle; ser_start_out=1; grant and sel are valid.
  - Go to BUSY and clear the watchdog.
- BUSY:
  - grant and sel are held constant. The watchdog increments each cycle.
  - On ser_done_in=1:
    - ack_out[sel] pulses next cycle and frame_cnt increments.
    - rr_ptr <= (sel+1) mod N_LAYERS.
    - Load the gap counter and go to GAP.
  - Else if the watchdog reaches TIMEOUT-1:
    - abort_out pulses next cycle; no ack; frame_cnt unchanged.
    - rr_ptr <= sel+1.
    - Go to GAP.
  - ser_done_in and timeout in the same cycle: done wins.
- GAP:
  - grant=0 (line low), sel holds its last value.
  - Count GAP_CYCLES cycles, then go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle t gives grant and start at t+1.
  - Done sampled at cycle d gives ack and grant drop at d+1.
  - GAP occupies d+1 .. d+GAP_CYCLES; IDLE at d+GAP_CYCLES+1; earliest next start at d+GAP_CYCLES+2.
- Ignored inputs:
  - ser_done_in in IDLE, START or GAP is ignored.
  - A request deasserting during START or BUSY does not cancel the transfer.
- enable_in:
  - Low only blocks the IDLE->START transition.
  - enable_in low mid-transfer has no effect until IDLE.
- Fairness: a continuously requesting layer waits at most N_LAYERS-1 other transfers.
- Invariants:
  - layer_grant_out is always one-hot or zero.
  - ack_out and abort_out are never both high.
  - Never more than one ack bit set.

Test Plan (GAP_CYCLES=4, TIMEOUT=16):
- Reset, then layer_req_in=8'h04, done 10 cycles after start: start at t+1 with sel=2, grant=8'h04; ack=8'h04 one cycle later; line low 4 cycles; frame_cnt=1.
- layer_req_in=8'hFF held, done after every start: grant order 0,1,...,7,0; consecutive starts spaced ≥ done latency + 6 cycles.
- Single request, ser_done_in never asserted: abort_out pulses 16 cycles after BUSY entry; no ack; frame_cnt unchanged; next grant goes to the next requester, not a retry of the same index first.
- ser_done_in pulsed in IDLE and GAP, plus request dropped mid-BUSY: no state change from the stray pulses; transfer completes and ack still issued.
- enable_in=0 with requests pending: stays IDLE with grant=0. Raise enable_in: start next cycle. Drop enable_in mid-BUSY: transfer completes normally.
- Assert rst_in during BUSY, then 256 successful transfers: all outputs 0 the cycle after reset; frame_cnt wraps 255->0.
